// File: rtl/dspm_way_cfg_ctrl.sv
// D-cache way reconfiguration sequencer: moves ways between cache and scratchpad mode.
// It drains the SPM port, flushes ways leaving cache mode, and zeroes every line of each
// way that changes mode. It then commits the new way masks.
module dspm_way_cfg_ctrl #(
  parameter int unsigned NR_WAYS      = 4,
  parameter int unsigned NUM_LINES    = 256,
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned MEMORY_WIDTH = 172,
  parameter int unsigned IDX_WIDTH    = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [NR_WAYS-1:0]            cfg_spm_ways_i,
  output logic [NR_WAYS-1:0]            spm_ways_o,
  output logic [NR_WAYS-1:0]            cache_ways_o,
  output logic                          busy_o,
  output logic                          spm_block_o,
  input  logic                          spm_idle_i,
  output logic                          flush_req_o,
  output logic [NR_WAYS-1:0]            flush_ways_o,
  input  logic                          flush_ack_i,
  output logic [NR_WAYS-1:0]            req_o,
  output logic [IDX_WIDTH-1:0]          addr_o,
  output logic                          we_o,
  output logic [(MEMORY_WIDTH+7)/8-1:0] be_o,
  output logic [MEMORY_WIDTH-1:0]       wdata_o,
  input  logic                          gnt_i
);

  localparam int unsigned CntW = $clog2(NUM_LINES);
  localparam int unsigned OffW = $clog2(LINE_WIDTH / 8);
  localparam int unsigned BeW  = (MEMORY_WIDTH + 7) / 8;

  typedef enum logic [2:0] {StIdle, StDrain, StFlush, StZero, StCommit} state_e;

  state_e              state_q, state_d;
  logic [NR_WAYS-1:0]  tgt_q, add_q, rem_q, zmask_q;
  logic [NR_WAYS-1:0]  spm_ways_q, cache_ways_q;
  logic [CntW-1:0]     cnt_q;
  logic [NR_WAYS-1:0]  add_new, rem_new;
  logic                accept, start, last_line;
  logic [IDX_WIDTH-1:0] cnt_ext;

  assign add_new   = cfg_spm_ways_i & ~spm_ways_q;
  assign rem_new   = spm_ways_q & ~cfg_spm_ways_i;
  assign accept    = (state_q == StIdle) && cfg_valid_i;
  // A request that changes nothing is accepted but starts no sequence.
  assign start     = accept && ((add_new | rem_new) != '0);
  assign last_line = (cnt_q == CntW'(NUM_LINES - 1));
  assign cnt_ext   = IDX_WIDTH'(cnt_q);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StDrain;
      StDrain:  if (spm_idle_i) state_d = (add_q != '0) ? StFlush : StZero;
      StFlush:  if (flush_ack_i) state_d = StZero;
      StZero:   if (gnt_i && last_line) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Configuration latches, way masks and line counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tgt_q        <= '0;
      add_q        <= '0;
      rem_q        <= '0;
      zmask_q      <= '0;
      spm_ways_q   <= '0;
      cache_ways_q <= '1;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        tgt_q   <= cfg_spm_ways_i;
        add_q   <= add_new;
        rem_q   <= rem_new;
        zmask_q <= add_new | rem_new;
      end
      // Changing ways become unusable by both sides before any flush or zeroing.
      if (state_q == StDrain && spm_idle_i) begin
        spm_ways_q   <= spm_ways_q & ~rem_q;
        cache_ways_q <= cache_ways_q & ~add_q;
      end
      if (state_q == StZero && gnt_i) cnt_q <= cnt_q + 1'b1;  // wraps to 0 on the last line
      if (state_q == StCommit) begin
        spm_ways_q   <= tgt_q;
        cache_ways_q <= ~tgt_q;
      end
    end
  end

  // Output decode.
  always_comb begin
    cfg_ready_o  = (state_q == StIdle);
    busy_o       = (state_q != StIdle);
    spm_block_o  = (state_q != StIdle);
    flush_req_o  = (state_q == StFlush);
    flush_ways_o = (state_q == StFlush) ? add_q : '0;
    req_o        = (state_q == StZero) ? zmask_q : '0;
    we_o         = (req_o != '0);
    be_o         = we_o ? {BeW{1'b1}} : '0;
    wdata_o      = '0;
    addr_o       = cnt_ext << OffW;
  end

  assign spm_ways_o   = spm_ways_q;
  assign cache_ways_o = cache_ways_q;

endmodule

// File: tb/tb_dspm_way_cfg_ctrl.sv
// Directed bench for dspm_way_cfg_ctrl. Inputs change and outputs are sampled on negedges.
module tb_dspm_way_cfg_ctrl;

  localparam int unsigned NrWays = 4;
  localparam int unsigned BeW    = (172 + 7) / 8;

  logic             clk_i = 1'b0;
  logic             rst_i, cfg_valid_i, spm_idle_i, flush_ack_i, gnt_i;
  logic [3:0]       cfg_spm_ways_i;
  logic             cfg_ready_o, busy_o, spm_block_o, flush_req_o, we_o;
  logic [3:0]       spm_ways_o, cache_ways_o, flush_ways_o, req_o;
  logic [11:0]      addr_o;
  logic [BeW-1:0]   be_o;
  logic [171:0]     wdata_o;

  int compares = 0;
  int fails    = 0;

  dspm_way_cfg_ctrl #(
    .NR_WAYS(NrWays), .NUM_LINES(256), .LINE_WIDTH(128), .MEMORY_WIDTH(172), .IDX_WIDTH(12)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_spm_ways_i(cfg_spm_ways_i), .spm_ways_o(spm_ways_o), .cache_ways_o(cache_ways_o),
    .busy_o(busy_o), .spm_block_o(spm_block_o), .spm_idle_i(spm_idle_i),
    .flush_req_o(flush_req_o), .flush_ways_o(flush_ways_o), .flush_ack_i(flush_ack_i),
    .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_spm_ways_i = '0; spm_idle_i = 1'b1;
    flush_ack_i = 1'b0; gnt_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    compares++; if (spm_ways_o !== 4'b0000) begin fails++;
      $display("FAIL reset_spm: got %b want 0000", spm_ways_o); end
    compares++; if (cache_ways_o !== 4'b1111) begin fails++;
      $display("FAIL reset_cache: got %b want 1111", cache_ways_o); end
    compares++; if ({cfg_ready_o, busy_o, spm_block_o, flush_req_o} !== 4'b1000) begin fails++;
      $display("FAIL reset_ctrl: got rdy/busy/blk/flush %b want 1000",
               {cfg_ready_o, busy_o, spm_block_o, flush_req_o}); end
    compares++; if ({req_o, flush_ways_o, we_o} !== 9'd0) begin fails++;
      $display("FAIL reset_req: got req %b fways %b we %b want all 0",
               req_o, flush_ways_o, we_o); end
  endtask

  // Runs ZERO to completion with a line-counter model; ends in the COMMIT cycle.
  task automatic zero_sweep(input logic [3:0] exp_req, input bit toggle, input string nm);
    int grants = 0;
    int cyc    = 0;
    int errs   = 0;
    logic [11:0] bad_addr = '0;
    logic [11:0] want_addr = '0;
    while (grants < 256 && cyc < 1200) begin
      gnt_i = toggle ? (cyc % 2 == 0) : 1'b1;
      want_addr = 12'(grants) << 4;
      if (addr_o !== want_addr || req_o !== exp_req || we_o !== 1'b1 || be_o !== '1 ||
          wdata_o !== '0) begin
        if (errs == 0) begin bad_addr = addr_o; end
        errs++;
      end
      tick();
      if (gnt_i) grants++;
      cyc++;
    end
    gnt_i = 1'b1;
    compares++; if (errs !== 0) begin fails++;
      $display("FAIL %s_writes: got %0d bad cycles (first addr %h) want 0", nm, errs, bad_addr);
    end
    compares++; if (req_o !== 4'b0000 || busy_o !== 1'b1) begin fails++;
      $display("FAIL %s_commit: got req %b busy %b want 0000 1 after 256 grants",
               nm, req_o, busy_o); end
  endtask

  task automatic test_first_cfg();
    cfg_valid_i = 1'b1; cfg_spm_ways_i = 4'b0011; spm_idle_i = 1'b1; gnt_i = 1'b1;
    compares++; if (cfg_ready_o !== 1'b1) begin fails++;
      $display("FAIL first_ready: got %b want 1", cfg_ready_o); end
    tick();
    cfg_valid_i = 1'b0;
    compares++; if ({cfg_ready_o, busy_o, spm_block_o} !== 3'b011) begin fails++;
      $display("FAIL first_drain: got rdy/busy/blk %b want 011",
               {cfg_ready_o, busy_o, spm_block_o}); end
    tick();
    compares++; if (flush_req_o !== 1'b1 || flush_ways_o !== 4'b0011) begin fails++;
      $display("FAIL first_flush: got req %b ways %b want 1 0011", flush_req_o, flush_ways_o); end
    compares++; if (spm_ways_o !== 4'b0000 || cache_ways_o !== 4'b1100) begin fails++;
      $display("FAIL first_drain_masks: got spm %b cache %b want 0000 1100",
               spm_ways_o, cache_ways_o); end
    tick();
    tick();
    compares++; if (flush_req_o !== 1'b1 || req_o !== 4'b0000) begin fails++;
      $display("FAIL first_flush_hold: got freq %b req %b want 1 0000", flush_req_o, req_o); end
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    compares++; if (flush_req_o !== 1'b0) begin fails++;
      $display("FAIL first_flush_drop: got %b want 0", flush_req_o); end
    zero_sweep(4'b0011, 1'b0, "first");
    tick();
    compares++; if (spm_ways_o !== 4'b0011 || cache_ways_o !== 4'b1100) begin fails++;
      $display("FAIL first_final: got spm %b cache %b want 0011 1100",
               spm_ways_o, cache_ways_o); end
    compares++; if (cfg_ready_o !== 1'b1 || busy_o !== 1'b0) begin fails++;
      $display("FAIL first_idle: got rdy %b busy %b want 1 0", cfg_ready_o, busy_o); end
  endtask

  task automatic test_no_flush();
    cfg_valid_i = 1'b1; cfg_spm_ways_i = 4'b0001;
    tick();
    cfg_valid_i = 1'b0;
    tick();
    compares++; if (flush_req_o !== 1'b0 || req_o !== 4'b0010) begin fails++;
      $display("FAIL noflush_zero: got freq %b req %b want 0 0010", flush_req_o, req_o); end
    compares++; if (spm_ways_o !== 4'b0001 || cache_ways_o !== 4'b1100) begin fails++;
      $display("FAIL noflush_mid: got spm %b cache %b want 0001 1100",
               spm_ways_o, cache_ways_o); end
    zero_sweep(4'b0010, 1'b0, "noflush");
    tick();
    compares++; if (spm_ways_o !== 4'b0001 || cache_ways_o !== 4'b1110) begin fails++;
      $display("FAIL noflush_final: got spm %b cache %b want 0001 1110",
               spm_ways_o, cache_ways_o); end
  endtask

  task automatic test_same_mask();
    cfg_valid_i = 1'b1; cfg_spm_ways_i = 4'b0001;
    compares++; if (cfg_ready_o !== 1'b1) begin fails++;
      $display("FAIL same_ready: got %b want 1", cfg_ready_o); end
    tick();
    cfg_valid_i = 1'b0;
    compares++; if ({busy_o, flush_req_o, req_o} !== 6'd0 || cfg_ready_o !== 1'b1) begin fails++;
      $display("FAIL same_idle: got busy %b freq %b req %b rdy %b want 0 0 0000 1",
               busy_o, flush_req_o, req_o, cfg_ready_o); end
    tick();
    compares++; if (busy_o !== 1'b0 || spm_ways_o !== 4'b0001) begin fails++;
      $display("FAIL same_hold: got busy %b spm %b want 0 0001", busy_o, spm_ways_o); end
  endtask

  task automatic test_drain_wait();
    int bad = 0;
    spm_idle_i = 1'b0;
    cfg_valid_i = 1'b1; cfg_spm_ways_i = 4'b0011;
    tick();
    cfg_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (spm_block_o !== 1'b1 || flush_req_o !== 1'b0 || spm_ways_o !== 4'b0001 ||
          cache_ways_o !== 4'b1110) bad++;
      tick();
    end
    compares++; if (bad !== 0) begin fails++;
      $display("FAIL drain_hold: got %0d bad cycles want 0", bad); end
    spm_idle_i = 1'b1;
    tick();
    compares++; if (flush_req_o !== 1'b1 || flush_ways_o !== 4'b0010 ||
                    cache_ways_o !== 4'b1100) begin fails++;
      $display("FAIL drain_exit: got freq %b fways %b cache %b want 1 0010 1100",
               flush_req_o, flush_ways_o, cache_ways_o); end
    // A request during FLUSH must not be accepted; ack in the first FLUSH cycle.
    cfg_valid_i = 1'b1; cfg_spm_ways_i = 4'b0100;
    compares++; if (cfg_ready_o !== 1'b0) begin fails++;
      $display("FAIL flush_ready: got %b want 0", cfg_ready_o); end
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0; cfg_valid_i = 1'b0;
    zero_sweep(4'b0010, 1'b1, "toggle");
    tick();
    compares++; if (spm_ways_o !== 4'b0011 || cache_ways_o !== 4'b1100) begin fails++;
      $display("FAIL toggle_final: got spm %b cache %b want 0011 1100",
               spm_ways_o, cache_ways_o); end
  endtask

  task automatic test_reset_mid_zero();
    cfg_valid_i = 1'b1; cfg_spm_ways_i = 4'b1100;
    tick();
    cfg_valid_i = 1'b0;
    tick();
    compares++; if (spm_ways_o !== 4'b0000 || cache_ways_o !== 4'b0000 ||
                    flush_ways_o !== 4'b1100) begin fails++;
      $display("FAIL swap_drain: got spm %b cache %b fways %b want 0000 0000 1100",
               spm_ways_o, cache_ways_o, flush_ways_o); end
    flush_ack_i = 1'b1;
    tick();
    flush_ack_i = 1'b0; gnt_i = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    compares++; if (addr_o !== 12'h640 || req_o !== 4'b1111) begin fails++;
      $display("FAIL swap_line100: got addr %h req %b want 640 1111", addr_o, req_o); end
    rst_i = 1'b1; cfg_valid_i = 1'b1; cfg_spm_ways_i = 4'b0110;
    tick();
    rst_i = 1'b0;
    compares++; if (spm_ways_o !== 4'b0000 || cache_ways_o !== 4'b1111 || req_o !== 4'b0000 ||
                    cfg_ready_o !== 1'b1 || busy_o !== 1'b0) begin fails++;
      $display("FAIL midreset: got spm %b cache %b req %b rdy %b busy %b want 0000 1111 0000 1 0",
               spm_ways_o, cache_ways_o, req_o, cfg_ready_o, busy_o); end
    tick();
    cfg_valid_i = 1'b0;
    compares++; if (busy_o !== 1'b1 || addr_o !== 12'h000) begin fails++;
      $display("FAIL post_reset_accept: got busy %b addr %h want 1 000", busy_o, addr_o); end
  endtask

  initial begin
    test_reset();
    test_first_cfg();
    test_no_flush();
    test_same_mask();
    test_drain_wait();
    test_reset_mid_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
